fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues in-order requests to instruction memory with a valid/ready handshake, and pairs each returned instruction with its PC.
- Buffers fetched instructions and presents them to decode through a valid/ready interface.
- On a redirect (branch/jump), discards everything in flight and drives a hold back to next-PC selection while it cannot accept an address.

---
 rtl/mips_pkg.sv | 11 +
 rtl/fetch_entry_buf.sv | 54 +++++
 rtl/fetch_stage.sv | 69 ++++++
 tb/tb_fetch_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, constants and fetch entry type for the front end
package mips_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0064;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_entry_buf.sv
// fetch_entry_buf: circular buffer of fetch entries with alloc, in-order fill and head pop
module fetch_entry_buf
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             alloc,
    input  logic [XLEN-1:0]  alloc_pc,
    input  logic             fill,
    input  logic [XLEN-1:0]  fill_instr,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    pending,
    output fetch_entry_t     head
);
    fetch_entry_t ent [DEPTH];
    logic [AW-1:0] head_ptr, fill_ptr, tail_ptr;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head_ptr <= '0;
            fill_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            pending  <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) ent[i].filled <= 1'b0;
            head_ptr <= '0;
            fill_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            pending  <= '0;
        end else begin
            // pop, alloc and fill always address distinct entries
            if (pop) ent[head_ptr].filled <= 1'b0;
            if (alloc) ent[tail_ptr] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
            if (fill) begin
                ent[fill_ptr].instr  <= fill_instr;
                ent[fill_ptr].filled <= 1'b1;
            end
            head_ptr <= head_ptr + AW'(pop);
            fill_ptr <= fill_ptr + AW'(fill);
            tail_ptr <= tail_ptr + AW'(alloc);
            count    <= count + CW'(alloc) - CW'(pop);
            pending  <= pending + CW'(alloc) - CW'(fill);
        end
    end
    assign head = ent[head_ptr];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: issues in-order imem requests from pc_in, pairs responses with PCs and feeds decode
module fetch_stage
    import mips_pkg::XLEN;
    import mips_pkg::fetch_entry_t;
#(
    parameter int              DEPTH   = 2,
    parameter logic [XLEN-1:0] PC_STEP = mips_pkg::PC_STEP
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_hold,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            flush,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    input  logic            id_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0] count, pending, drop_cnt;
    logic [CW:0]   used;
    logic          hs, rsp_drop, fill, pop;
    fetch_entry_t  head;
    always_comb begin
        used           = {1'b0, count} + {1'b0, drop_cnt};
        // held low in reset so next-PC select sees pc_hold until release
        imem_req_valid = reset_n && !flush && (used < (CW+1)'(DEPTH));
        hs             = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
        fill           = imem_rsp_valid && !rsp_drop && (pending != '0) && !flush;
        id_valid       = head.filled && !flush;
        pop            = id_valid && id_ready;
    end
    assign imem_req_addr = pc_in;
    assign pc_hold       = !hs;
    assign id_instr      = head.instr;
    assign id_pc         = head.pc;
    assign id_pc_plus4   = head.pc + PC_STEP;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_cnt <= '0;
        else if (flush)
            drop_cnt <= drop_cnt + pending - CW'(imem_rsp_valid && (drop_cnt != '0 || pending != '0));
        else
            drop_cnt <= drop_cnt - CW'(rsp_drop);
    end
    fetch_entry_buf #(.DEPTH(DEPTH)) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (flush),
        .alloc      (hs),
        .alloc_pc   (pc_in),
        .fill       (fill),
        .fill_instr (imem_rsp_data),
        .pop        (pop),
        .count      (count),
        .pending    (pending),
        .head       (head)
    );
    // a response with nothing outstanding is a memory protocol violation
    assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_rsp_valid && drop_cnt == '0 && pending == '0));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard queue checked by an independent decode monitor
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc_in = 32'h64;
    logic        pc_hold;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, id_pc_plus4;
    logic        id_ready = 1'b1;

    always #5 clk = ~clk;

    fetch_stage #(.DEPTH(2), .PC_STEP(32'd4)) dut (
        .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .pc_hold(pc_hold),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .flush(flush), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_ready(id_ready)
    );

    int checks = 0, errors = 0, cyc = 0, lat = 1, accepted = 0, a0 = 0;
    logic [31:0] sb[$];
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // memory model: fixed latency, in-order responses
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            imem_rsp_valid = 1'b0;
            if (!reset_n) begin
                mq_addr.delete();
                mq_due.delete();
            end else if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc + lat);
            end
        end
    end

    // decode-side monitor
    initial begin : mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && id_valid && id_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_id: got pc %h, expected no instruction", id_pc);
                end else begin
                    e = sb.pop_front();
                    chk("id_pc", id_pc, e);
                    chk("id_pc_plus4", id_pc_plus4, e + 32'd4);
                    chk("id_instr", id_instr, instr_of(e));
                end
            end
        end
    end

    task automatic cyc_end();
        logic hs;
        hs = imem_req_valid && imem_req_ready;
        if (hs) begin
            sb.push_back(pc_in);
            accepted++;
        end
        @(posedge clk); #1;
        if (hs) pc_in = pc_in + 32'd4;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc_end();
        end
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        run(8);
        chk("drained", sb.size(), 0);
    endtask

    task automatic flush_now(input logic [31:0] npc);
        flush = 1'b1;
        @(negedge clk);
        chk1("flush_id_valid", id_valid, 1'b0);
        chk1("flush_req_valid", imem_req_valid, 1'b0);
        chk1("flush_pc_hold", pc_hold, 1'b1);
        sb.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        pc_in = npc;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rst_id_valid", id_valid, 1'b0);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_pc_hold", pc_hold, 1'b1);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h4);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk1("rel_req_valid", imem_req_valid, 1'b1);
        chk("rel_req_addr", imem_req_addr, 32'h64);
        chk1("rel_pc_hold", pc_hold, 1'b0);
        cyc_end();
        run(1);
        @(negedge clk);
        chk1("first_id_valid", id_valid, 1'b1);
        chk("first_id_pc", id_pc, 32'h64);
        chk("first_id_pc_plus4", id_pc_plus4, 32'h68);
        chk("first_id_instr", id_instr, 32'hC0DE_0064);
        chk1("full_req_valid", imem_req_valid, 1'b0);
        chk1("full_pc_hold", pc_hold, 1'b1);
        cyc_end();
        run(6);

        // decode backpressure
        id_ready = 1'b0;
        run(5);
        @(negedge clk);
        chk1("bp_req_valid", imem_req_valid, 1'b0);
        chk1("bp_pc_hold", pc_hold, 1'b1);
        chk1("bp_id_valid", id_valid, 1'b1);
        chk("bp_entries", sb.size(), 2);
        chk("bp_id_pc", id_pc, sb[0]);
        cyc_end();
        run(2);
        @(negedge clk);
        chk1("bp_hold_valid", id_valid, 1'b1);
        chk("bp_hold_pc", id_pc, sb[0]);
        chk("bp_hold_instr", id_instr, instr_of(sb[0]));
        chk("bp_hold_plus4", id_pc_plus4, sb[0] + 32'd4);
        cyc_end();
        id_ready = 1'b1;
        run(8);
        drain();

        // flush with two fetches in flight, 3-cycle memory
        imem_req_ready = 1'b1;
        lat = 3;
        pc_in = 32'h100;
        run(2);
        flush_now(32'h200);
        @(negedge clk);
        chk1("drop_req_valid", imem_req_valid, 1'b0);
        cyc_end();
        @(negedge clk);
        chk1("resume_req_valid", imem_req_valid, 1'b1);
        chk("resume_req_addr", imem_req_addr, 32'h200);
        cyc_end();
        run(8);
        drain();

        // flush coincident with a response and id_ready high
        imem_req_ready = 1'b1;
        lat = 1;
        pc_in = 32'h280;
        run(2);
        flush_now(32'h300);
        @(negedge clk);
        chk1("post_flush_id_valid", id_valid, 1'b0);
        chk1("post_flush_req_valid", imem_req_valid, 1'b1);
        chk("post_flush_addr", imem_req_addr, 32'h300);
        cyc_end();
        run(6);
        drain();

        // memory stall
        pc_in = 32'h400;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("stall_pc_hold", pc_hold, 1'b1);
            chk1("stall_req_valid", imem_req_valid, 1'b1);
            chk("stall_req_addr", imem_req_addr, 32'h400);
            cyc_end();
        end
        imem_req_ready = 1'b1;
        a0 = accepted;
        @(negedge clk);
        chk1("unstall_pc_hold", pc_hold, 1'b0);
        cyc_end();
        imem_req_ready = 1'b0;
        run(4);
        chk("unstall_accepts", accepted - a0, 1);
        drain();

        // reset in the middle of a stream
        imem_req_ready = 1'b1;
        pc_in = 32'h500;
        run(3);
        reset_n = 1'b0;
        @(negedge clk);
        chk1("mid_rst_req_valid", imem_req_valid, 1'b0);
        chk1("mid_rst_pc_hold", pc_hold, 1'b1);
        chk1("mid_rst_id_valid", id_valid, 1'b0);
        chk("mid_rst_id_pc", id_pc, 32'h0);
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        pc_in = 32'h64;
        @(negedge clk);
        chk1("rel2_req_valid", imem_req_valid, 1'b1);
        chk("rel2_req_addr", imem_req_addr, 32'h64);
        chk1("rel2_pc_hold", pc_hold, 1'b0);
        cyc_end();
        run(8);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
